// File: rtl/slow_clock_pkg.sv
`default_nettype none
// ============================================================================
// Package  : slow_clock_pkg
// Summary  : Shared state encoding and constants for the slow-clock generator.
// Revision : 1.0
// ============================================================================
package slow_clock_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN_LO    = 3'd1,
        RUN_HI    = 3'd2,
        STEP_WAIT = 3'd3,
        STEP_HI   = 3'd4,
        LOAD      = 3'd5
    } state_t;

    localparam int SYNC_STAGES = 2;

    function automatic logic is_high_phase(input state_t s);
        return (s == RUN_HI) || (s == STEP_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : step_debouncer
// Summary  : Stable-level debouncer; level follows the input only after it has
//            differed from the current level for DB_CYCLES consecutive cycles.
// Revision : 1.0
// ============================================================================
module step_debouncer #(
    parameter int DB_CYCLES = 120000
) (
    input  logic fastClk,
    input  logic rst,
    input  logic din,
    output logic level_o,
    output logic rise_o
);

    localparam int                 c_CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DB_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;
    logic               r_rise;

    always_ff @(posedge fastClk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            if (din == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_LAST) begin
                r_cnt   <= '0;
                r_level <= din;
                r_rise  <= din;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level_o = r_level;
    assign rise_o  = r_rise;

endmodule
`default_nettype wire

// File: rtl/slow_clock_gen.sv
`default_nettype none
// ============================================================================
// Module   : slow_clock_gen
// Summary  : RUN / STEP / HALT slow-clock generator with serially loaded
//            half-period. Define SLOWCLK_DEBOUNCE_EN to debounce step_btn.
// Revision : 1.0
// ============================================================================
module slow_clock_gen
    import slow_clock_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int DB_CYCLES = 120000
) (
    input  logic       fastClk,
    input  logic       rst,
    input  logic       cfg_load,
    input  logic       cfg_data,
    input  logic       mode_step,
    input  logic       step_btn,
    input  logic       halt,
    output logic       slowClk,
    output logic       cfg_err,
    output logic [2:0] state_o
);

    localparam int                    c_BITCNT_W = $clog2(CNT_W + 2);
    localparam logic [c_BITCNT_W-1:0] c_BITS_OK  = c_BITCNT_W'(CNT_W);
    localparam logic [c_BITCNT_W-1:0] c_BITS_SAT = c_BITCNT_W'(CNT_W + 1);

    logic [SYNC_STAGES-1:0][4:0] r_sync;
    logic w_load, w_data, w_mode, w_btn, w_halt, w_step_rise;

    always_ff @(posedge fastClk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= {cfg_load, cfg_data, mode_step, step_btn, halt};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign {w_load, w_data, w_mode, w_btn, w_halt} = r_sync[SYNC_STAGES-1];

`ifdef SLOWCLK_DEBOUNCE_EN
    logic w_db_level_unused;

    step_debouncer #(
        .DB_CYCLES (DB_CYCLES)
    ) u_step_debouncer (
        .fastClk (fastClk),
        .rst     (rst),
        .din     (w_btn),
        .level_o (w_db_level_unused),
        .rise_o  (w_step_rise)
    );
`else
    logic r_btn_d;
    logic w_unused_db;

    always_ff @(posedge fastClk or negedge rst) begin
        if (!rst) r_btn_d <= 1'b0;
        else      r_btn_d <= w_btn;
    end

    assign w_step_rise = w_btn & ~r_btn_d;
    assign w_unused_db = (DB_CYCLES == 0);
`endif

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_count, w_count_nxt, r_half, r_shift;
    logic [c_BITCNT_W-1:0] r_bitcnt;
    logic                  r_slow, r_err;
    logic                  w_frame_start, w_shift, w_commit, w_reject, w_at_end;

    assign w_at_end = (r_count == r_half);

    // Load requests are only honoured from low phases so slowClk never glitches.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_frame_start = 1'b0;
        w_shift       = 1'b0;
        w_commit      = 1'b0;
        w_reject      = 1'b0;
        case (r_state)
            IDLE: begin
                w_count_nxt = '0;
                if (w_load) begin
                    w_state_nxt   = LOAD;
                    w_frame_start = 1'b1;
                end else if (!w_halt) begin
                    w_state_nxt = w_mode ? STEP_WAIT : RUN_LO;
                end
            end
            RUN_LO: begin
                if (w_load) begin
                    w_state_nxt   = LOAD;
                    w_frame_start = 1'b1;
                    w_count_nxt   = '0;
                end else if (w_halt || w_mode) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                end else if (w_at_end) begin
                    w_state_nxt = RUN_HI;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            RUN_HI: begin
                if (w_at_end) begin
                    w_state_nxt = w_halt ? IDLE : RUN_LO;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            STEP_WAIT: begin
                w_count_nxt = '0;
                if (w_load) begin
                    w_state_nxt   = LOAD;
                    w_frame_start = 1'b1;
                end else if (!w_mode) begin
                    w_state_nxt = IDLE;
                end else if (w_step_rise && !w_halt) begin
                    w_state_nxt = STEP_HI;
                end
            end
            STEP_HI: begin
                if (w_at_end) begin
                    w_state_nxt = STEP_WAIT;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            LOAD: begin
                w_count_nxt = '0;
                if (w_load) begin
                    w_shift = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                    w_commit    = (r_bitcnt == c_BITS_OK);
                    w_reject    = (r_bitcnt != c_BITS_OK);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge fastClk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_half   <= '0;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_slow   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_slow  <= is_high_phase(w_state_nxt);
            r_err   <= w_reject;
            // The first bit of a frame is captured on the entry cycle itself.
            if (w_frame_start) begin
                r_shift  <= {w_data, r_shift[CNT_W-1:1]};
                r_bitcnt <= c_BITCNT_W'(1);
            end else if (w_shift) begin
                r_shift <= {w_data, r_shift[CNT_W-1:1]};
                if (r_bitcnt != c_BITS_SAT) r_bitcnt <= r_bitcnt + 1'b1;
            end
            if (w_commit) r_half <= r_shift;
        end
    end

    assign slowClk = r_slow;
    assign cfg_err = r_err;
    assign state_o = r_state;

endmodule
`default_nettype wire
